// File: rtl/temp_parser_pkg.sv
// Shared definitions for the ASCII temperature parser: byte constants, FSM
// encoding and the gap-timeout derivation.
package temp_parser_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;

    typedef enum logic [1:0] {
        StIdle,
        StSign,
        StInt,
        StFrac
    } state_e;

    function automatic int unsigned timeout_cyc(input int unsigned clk_fre,
                                                 input int unsigned timeout_ms);
        return clk_fre / 1000 * timeout_ms;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Saturating idle-gap counter: counts cycles since the last clear and flags
// timeout once the count has reached TimeoutCyc.
module gap_timer #(
    parameter int unsigned TimeoutCyc = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic timeout_o
);

    localparam int unsigned CntW = $clog2(TimeoutCyc + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCyc);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == CntMax);

endmodule

// File: rtl/temp_parser.sv
// Extracts one signed decimal temperature (e.g. "23.5", "-7") from a UART byte
// stream and presents registered sign/integer/tenths fields with valid/err pulses.
module temp_parser
    import temp_parser_pkg::*;
#(
    parameter int unsigned CLK_FRE        = 50_000_000,
    parameter int unsigned TIMEOUT_MS     = 20,
    parameter int unsigned MAX_INT_DIGITS = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cfg_done,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       po_sign,
    output logic [6:0] po_int,
    output logic [3:0] po_frac,
    output logic       po_valid,
    output logic       po_err
);

    localparam int unsigned TIMEOUT_CYC = timeout_cyc(CLK_FRE, TIMEOUT_MS);
    localparam int unsigned CntW        = $clog2(MAX_INT_DIGITS + 1);

    state_e          state_q, state_d;
    logic [9:0]      acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [3:0]      frac_q, frac_d;
    logic            fseen_q, fseen_d;
    logic            sign_q, sign_d;
    logic [6:0]      int_q, int_d;
    logic [3:0]      fout_q, fout_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic            is_digit;
    logic [3:0]      digit;
    logic            timeout;
    logic            commit;
    logic [3:0]      commit_frac;

    assign is_digit = (pi_data >= ASCII_0) && (pi_data <= ASCII_9);
    assign digit    = pi_data[3:0];

    gap_timer #(
        .TimeoutCyc(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk_i    (sys_clk),
        .rst_ni   (sys_rst_n),
        .clr_i    (pi_flag),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        frac_d      = frac_q;
        fseen_d     = fseen_q;
        sign_d      = sign_q;
        int_d       = int_q;
        fout_d      = fout_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        commit      = 1'b0;
        commit_frac = frac_q;

        if (!cfg_done) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pi_flag) begin
                        if (pi_data == ASCII_MINUS) begin
                            state_d = StSign;
                            neg_d   = 1'b1;
                        end else if (is_digit) begin
                            state_d = StInt;
                            acc_d   = {6'b0, digit};
                            cnt_d   = CntW'(1);
                            neg_d   = 1'b0;
                        end
                    end
                end
                StSign: begin
                    if (pi_flag) begin
                        if (is_digit) begin
                            state_d = StInt;
                            acc_d   = {6'b0, digit};
                            cnt_d   = CntW'(1);
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (timeout) begin
                        state_d = StIdle;
                    end
                end
                StInt: begin
                    if (pi_flag) begin
                        if (is_digit) begin
                            if (cnt_q < CntW'(MAX_INT_DIGITS)) begin
                                acc_d = (acc_q << 3) + (acc_q << 1) + {6'b0, digit};
                                cnt_d = cnt_q + CntW'(1);
                            end else begin
                                err_d   = 1'b1;
                                state_d = StIdle;
                            end
                        end else if (pi_data == ASCII_DOT) begin
                            state_d = StFrac;
                            frac_d  = '0;
                            fseen_d = 1'b0;
                        end else begin
                            commit      = 1'b1;
                            commit_frac = '0;
                        end
                    end else if (timeout) begin
                        commit      = 1'b1;
                        commit_frac = '0;
                    end
                end
                StFrac: begin
                    if (pi_flag) begin
                        if (is_digit) begin
                            // Only the tenths digit is kept; further digits truncate.
                            if (!fseen_q) begin
                                frac_d  = digit;
                                fseen_d = 1'b1;
                            end
                        end else begin
                            commit = 1'b1;
                        end
                    end else if (timeout) begin
                        commit = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (commit) begin
                state_d = StIdle;
                if (acc_q > 10'd127) begin
                    err_d = 1'b1;
                end else begin
                    sign_d  = neg_q;
                    int_d   = acc_q[6:0];
                    fout_d  = commit_frac;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            frac_q  <= '0;
            fseen_q <= 1'b0;
            sign_q  <= 1'b0;
            int_q   <= '0;
            fout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            frac_q  <= frac_d;
            fseen_q <= fseen_d;
            sign_q  <= sign_d;
            int_q   <= int_d;
            fout_q  <= fout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign po_sign  = sign_q;
    assign po_int   = int_q;
    assign po_frac  = fout_q;
    assign po_valid = valid_q;
    assign po_err   = err_q;

endmodule

// File: tb/tb_temp_parser.sv
// Scoreboard bench for temp_parser: a token-level reference model queues expected
// pulses (kind, fields, cycle) and a negedge monitor checks every DUT pulse.
module tb_temp_parser;

    localparam int unsigned CLK_FRE    = 100_000;
    localparam int unsigned TIMEOUT_MS = 1;
    localparam int unsigned MAXD       = 3;
    localparam int          T          = CLK_FRE / 1000 * TIMEOUT_MS;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       cfg_done = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic       po_sign;
    logic [6:0] po_int;
    logic [3:0] po_frac;
    logic       po_valid;
    logic       po_err;

    temp_parser #(
        .CLK_FRE       (CLK_FRE),
        .TIMEOUT_MS    (TIMEOUT_MS),
        .MAX_INT_DIGITS(MAXD)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .cfg_done (cfg_done),
        .pi_data  (pi_data),
        .pi_flag  (pi_flag),
        .po_sign  (po_sign),
        .po_int   (po_int),
        .po_frac  (po_frac),
        .po_valid (po_valid),
        .po_err   (po_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        bit sign;
        int ival;
        int frac;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a token being collected plus the value currently displayed.
    bit   m_active;
    bit   m_neg;
    bit   m_dot;
    int   m_int[$];
    int   m_frac[$];
    bit   h_sign;
    int   h_int;
    int   h_frac;
    int   last_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit is_err, input int at);
        exp_t e;
        e.is_err = is_err;
        e.sign   = h_sign;
        e.ival   = h_int;
        e.frac   = h_frac;
        e.at     = at;
        q.push_back(e);
    endtask

    task automatic m_commit(input int at);
        int v;
        v = 0;
        foreach (m_int[i]) v = v * 10 + m_int[i];
        if (v > 127) begin
            push_exp(1'b1, at);
        end else begin
            h_sign = m_neg;
            h_int  = v;
            h_frac = (m_frac.size() > 0) ? m_frac[0] : 0;
            push_exp(1'b0, at);
        end
        m_active = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b, input int at);
        bit is_dig;
        int d;
        is_dig = (b >= 8'h30) && (b <= 8'h39);
        d      = int'(b) - 48;
        if (!m_active) begin
            if (b == 8'h2D || is_dig) begin
                m_active = 1'b1;
                m_neg    = (b == 8'h2D);
                m_dot    = 1'b0;
                m_int.delete();
                m_frac.delete();
                if (is_dig) m_int.push_back(d);
            end
        end else if (m_int.size() == 0) begin
            if (is_dig) m_int.push_back(d);
            else m_active = 1'b0;
        end else if (!m_dot) begin
            if (is_dig) begin
                if (m_int.size() >= int'(MAXD)) begin
                    push_exp(1'b1, at);
                    m_active = 1'b0;
                end else begin
                    m_int.push_back(d);
                end
            end else if (b == 8'h2E) begin
                m_dot = 1'b1;
            end else begin
                m_commit(at);
            end
        end else begin
            if (is_dig) m_frac.push_back(d);
            else m_commit(at);
        end
    endtask

    task automatic m_timeout(input int at);
        if (m_active) begin
            if (m_int.size() == 0) m_active = 1'b0;
            else m_commit(at);
        end
    endtask

    // Called at a negedge; returns at a negedge. gap=0 gives back-to-back strobes.
    task automatic send(input logic [7:0] b, input int gap);
        pi_data = b;
        pi_flag = 1'b1;
        last_c  = cyc;
        if (cfg_done) m_byte(b, cyc + 1);
        @(negedge sys_clk);
        pi_flag = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic silence();
        m_timeout(last_c + T + 2);
        repeat (T + 30) @(negedge sys_clk);
    endtask

    task automatic rand_token();
        int kind;
        int nd;
        int nf;
        int term;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            send_str("OK+IPD:", $urandom_range(0, 4));
        end else begin
            if ($urandom_range(0, 3) == 0) send(8'h2D, $urandom_range(0, 6));
            nd = $urandom_range(1, 4);
            for (int i = 0; i < nd; i++) send(8'h30 + 8'($urandom_range(0, 9)), $urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) begin
                send(8'h2E, $urandom_range(0, 6));
                nf = $urandom_range(0, 2);
                for (int i = 0; i < nf; i++) send(8'h30 + 8'($urandom_range(0, 9)), $urandom_range(0, 6));
            end
            term = $urandom_range(0, 4);
            case (term)
                0: silence();
                1: send(8'h20, $urandom_range(0, 6));
                2: send(8'h0D, $urandom_range(0, 6));
                3: send(8'h2C, $urandom_range(0, 6));
                default: send(8'h2D, $urandom_range(0, 6));
            endcase
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        h_sign   = 1'b0;
        h_int    = 0;
        h_frac   = 0;
    endtask

    always @(negedge sys_clk) begin
        if (po_valid || po_err) begin
            check("pulse_exclusive", {31'b0, po_valid & po_err}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'b0, po_valid, po_err}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("pulse_kind_err", {31'b0, po_err}, {31'b0, mon_e.is_err});
                check("po_sign", {31'b0, po_sign}, {31'b0, mon_e.sign});
                check("po_int", {25'b0, po_int}, mon_e.ival);
                check("po_frac", {28'b0, po_frac}, mon_e.frac);
                check("pulse_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        last_c    = 0;
        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst_sign", {31'b0, po_sign}, 32'd0);
        check("rst_int", {25'b0, po_int}, 32'd0);
        check("rst_frac", {28'b0, po_frac}, 32'd0);
        check("rst_valid", {31'b0, po_valid}, 32'd0);
        check("rst_err", {31'b0, po_err}, 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        cfg_done = 1'b1;
        @(negedge sys_clk);

        send_str("23.5", 3);
        send(8'h0D, 3);
        send(8'h0A, 5);
        check("hold_23_5_int", {25'b0, po_int}, 32'd23);

        send_str("HTTP/1.1 200 OK -7", 2);
        silence();
        check("http_final_sign", {31'b0, po_sign}, 32'd1);
        check("http_final_int", {25'b0, po_int}, 32'd7);

        send_str("1000", 2);
        send(8'h0D, 4);
        send_str("200", 2);
        send(8'h0A, 4);
        send_str("127", 2);
        send(8'h0A, 4);
        check("max_int", {25'b0, po_int}, 32'd127);

        send_str("-x", 3);
        send_str("9.87 ", 3);
        send_str("-0.5 ", 1);
        send_str("42.1,", 0);
        send_str("12", 1);
        silence();
        send(8'h2D, 1);
        silence();
        send_str("5.", 1);
        silence();

        // Number in progress abandoned by dropping cfg_done.
        send(8'h34, 3);
        cfg_done = 1'b0;
        m_active = 1'b0;
        repeat (3) @(negedge sys_clk);
        send(8'h0D, 2);
        cfg_done = 1'b1;
        @(negedge sys_clk);
        send(8'h0D, 5);

        send_str("88.8 ", 2);
        send(8'h35, 3);
        #2 sys_rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_int", {25'b0, po_int}, 32'd0);
        check("midrst_frac", {28'b0, po_frac}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        send(8'h0D, 5);

        for (int k = 0; k < 60; k++) rand_token();

        repeat (T + 10) @(negedge sys_clk);
        check("missing_pulses", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
